decode_issue_unit: RTL and testbench
====================================

DECODE_ISSUE_UNIT -- requirements
Module: decode_issue_unit

Interface
REQ-001 Parameter: RF_INIT, default 16'd0, value loaded into every register-file entry on reset.
REQ-002 clkwire  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset, sampled on rising clkwire.
REQ-004 in_valid  input  1  fetch presents an instruction.
REQ-005 in_instr  input  16  instruction word: [15:12] opcode; [11:8] A; [7:4] B; [3:0] C.
REQ-006 in_pc  input  8  address of in_instr.
REQ-007 in_ready  output  1  decode accepts in_instr this cycle.
REQ-008 wb_en  input  1  writeback strobe from memory stage.
REQ-009 wb_reg  input  4  writeback destination.
REQ-010 wb_data  input  16  writeback value.
REQ-011 flush  input  1  taken-branch squash.
REQ-012 out_valid  output  1  ID/EX latch holds a live instruction.
REQ-013 op1, op2  output  16 each  source operands to execution unit.
REQ-014 imm  output  8  zero-extended immediate.
REQ-015 npci  output  8  in_pc + 1, modulo 256.
REQ-016 regdesti  output  4  destination register.
REQ-017 ldsti  output  4  memory line number.
REQ-018 instructioni  output  4  opcode forwarded to execution unit.

Function
REQ-019 Opcodes: 0000 add, 0001 sub, 0010 mul, 0011 load, 0100 store, 0101 beq, 0110 bnq; 0111-1111 are NOP.
REQ-020 add/sub/mul: rd=A, rs1=B, rs2=C; op1=R[B], op2=R[C], regdesti=A, imm=0, ldsti=0.
REQ-021 load: rd=A; imm={B,C}; ldsti=C; op1=op2=0; regdesti=A.
REQ-022 store: rs=A; op2=R[A]; imm={B,C}; ldsti=C; op1=0; regdesti=0.
REQ-023 beq/bnq: op1=R[A], op2=R[B], imm={4'b0,C}, regdesti=0, ldsti=0.
REQ-024 Scoreboard: 16 busy bits; issue of add/sub/mul/load sets busy[rd]; wb_en clears busy[wb_reg].
REQ-025 Hazard: any source register with busy set, and not cleared by wb_en this cycle, holds in_ready low.
REQ-026 Accept = in_valid & in_ready & ~flush; on accept the ID/EX latch loads next edge, out_valid=1; otherwise out_valid=0.
REQ-027 Latency: one cycle from accept to out_valid; execution stage never back-pressures.
REQ-028 Bypass: a source equal to wb_reg while wb_en=1 reads wb_data in the same cycle.
REQ-029 Same-cycle set/clear of one busy bit: set wins.
REQ-030 Register file: wb_en writes R[wb_reg]=wb_data at the edge; no write lock on any register.
REQ-031 flush: out_valid=0 next edge; instruction offered that cycle is discarded; busy bits unchanged.
REQ-032 NOP: accepted, consumed, out_valid stays 0, scoreboard unchanged.
REQ-033 Stalled instruction: outputs hold last values; out_valid=0 during stall.

Reset
REQ-034 resetn=0 at an edge: all R[i]=RF_INIT; busy=0; out_valid=0; op1, op2, imm, npci, regdesti, ldsti, instructioni=0; in_ready=1 once resetn=1.
REQ-035 Reset overrides flush, wb_en and accept in the same cycle; an in-flight instruction is dropped.

Verification
REQ-036 Write R1=10, R2=12 via wb; issue add R5,R1,R2 (0x0512) at pc=9 -> next cycle out_valid=1, op1=10, op2=12, npci=10, regdesti=5, instructioni=0000.
REQ-037 Issue sub R3,R1,R2, then add R4,R3,R1 -> in_ready=0 until wb_en with wb_reg=3; on that cycle in_ready=1 and op1 equals wb_data.
REQ-038 Issue load with A=7, imm=0x39 -> ldsti=9, imm=0x39, regdesti=7, busy[7]=1; cycle with wb_en, wb_reg=7 clears it.
REQ-039 flush asserted with in_valid=1 -> out_valid=0 next cycle; busy bits unchanged.
REQ-040 in_pc=255 -> npci=0; opcode 1010 -> out_valid stays 0.
REQ-041 resetn low mid-stall -> next cycle busy=0, out_valid=0, in_ready=1, R[*]=RF_INIT.

Source files
------------

// File: rtl/decode_issue_unit.sv
// Decode/issue stage: splits the instruction word, reads the register file with
// writeback bypass, checks the busy scoreboard and fills the ID/EX latch.
module decode_issue_unit #(
  parameter logic [15:0] RF_INIT = 16'd0
) (
  input  logic        clkwire,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  input  logic [7:0]  in_pc,
  output logic        in_ready,
  input  logic        wb_en,
  input  logic [3:0]  wb_reg,
  input  logic [15:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  output logic [15:0] op1,
  output logic [15:0] op2,
  output logic [7:0]  imm,
  output logic [7:0]  npci,
  output logic [3:0]  regdesti,
  output logic [3:0]  ldsti,
  output logic [3:0]  instructioni
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_MUL   = 4'h2,
    OP_LOAD  = 4'h3,
    OP_STORE = 4'h4,
    OP_BEQ   = 4'h5,
    OP_BNQ   = 4'h6
  } opcode_e;

  logic [15:0] rf [16];
  logic [15:0] busy;

  opcode_e     opc;
  logic [3:0]  fa, fb, fc;
  logic [15:0] val_a, val_b, val_c;
  logic [15:0] clr_vec, set_vec, pending;

  logic        src1_use, src2_use;
  logic [3:0]  src1_idx, src2_idx;
  logic        live, writes_rd, hazard, accept;
  logic [15:0] d_op1, d_op2;
  logic [7:0]  d_imm;
  logic [3:0]  d_ldst, d_rd;

  assign opc = opcode_e'(in_instr[15:12]);
  assign fa  = in_instr[11:8];
  assign fb  = in_instr[7:4];
  assign fc  = in_instr[3:0];

  // A register being written this cycle is read straight from the writeback bus.
  assign val_a = (wb_en && wb_reg == fa) ? wb_data : rf[fa];
  assign val_b = (wb_en && wb_reg == fb) ? wb_data : rf[fb];
  assign val_c = (wb_en && wb_reg == fc) ? wb_data : rf[fc];

  assign clr_vec = wb_en ? (16'(1) << wb_reg) : '0;
  assign pending = busy & ~clr_vec;

  always_comb begin
    src1_use  = 1'b0;
    src2_use  = 1'b0;
    src1_idx  = fb;
    src2_idx  = fc;
    live      = 1'b0;
    writes_rd = 1'b0;
    d_op1     = '0;
    d_op2     = '0;
    d_imm     = '0;
    d_ldst    = '0;
    d_rd      = '0;
    case (opc)
      OP_ADD, OP_SUB, OP_MUL: begin
        src1_use  = 1'b1;
        src2_use  = 1'b1;
        src1_idx  = fb;
        src2_idx  = fc;
        d_op1     = val_b;
        d_op2     = val_c;
        d_rd      = fa;
        live      = 1'b1;
        writes_rd = 1'b1;
      end
      OP_LOAD: begin
        d_imm     = {fb, fc};
        d_ldst    = fc;
        d_rd      = fa;
        live      = 1'b1;
        writes_rd = 1'b1;
      end
      OP_STORE: begin
        src1_use = 1'b1;
        src1_idx = fa;
        d_op2    = val_a;
        d_imm    = {fb, fc};
        d_ldst   = fc;
        live     = 1'b1;
      end
      OP_BEQ, OP_BNQ: begin
        src1_use = 1'b1;
        src2_use = 1'b1;
        src1_idx = fa;
        src2_idx = fb;
        d_op1    = val_a;
        d_op2    = val_b;
        d_imm    = {4'b0, fc};
        live     = 1'b1;
      end
      default: ;
    endcase
  end

  assign hazard   = (src1_use && pending[src1_idx]) || (src2_use && pending[src2_idx]);
  assign in_ready = ~hazard;
  assign accept   = in_valid && in_ready && !flush;
  assign set_vec  = (accept && writes_rd) ? (16'(1) << fa) : '0;

  // NOPs are consumed without touching the latch or the scoreboard.
  always_ff @(posedge clkwire) begin
    if (!resetn) begin
      rf           <= '{default: RF_INIT};
      busy         <= '0;
      out_valid    <= 1'b0;
      op1          <= '0;
      op2          <= '0;
      imm          <= '0;
      npci         <= '0;
      regdesti     <= '0;
      ldsti        <= '0;
      instructioni <= '0;
    end else begin
      if (wb_en)
        rf[wb_reg] <= wb_data;
      busy      <= (busy & ~clr_vec) | set_vec;
      out_valid <= accept && live;
      if (accept && live) begin
        op1          <= d_op1;
        op2          <= d_op2;
        imm          <= d_imm;
        npci         <= in_pc + 8'd1;
        regdesti     <= d_rd;
        ldsti        <= d_ldst;
        instructioni <= in_instr[15:12];
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_unit.sv
// Bench for decode_issue_unit: directed scenarios plus randomized traffic
// checked against an architectural model of registers, scoreboard and latch.
module tb_decode_issue_unit;

  localparam logic [15:0] INIT = 16'h1234;

  logic        clkwire = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic [7:0]  in_pc = '0;
  logic        in_ready;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_reg = '0;
  logic [15:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [15:0] op1, op2;
  logic [7:0]  imm, npci;
  logic [3:0]  regdesti, ldsti, instructioni;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clkwire = ~clkwire;

  decode_issue_unit #(.RF_INIT(INIT)) dut (
    .clkwire(clkwire), .resetn(resetn), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .in_ready(in_ready), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .op1(op1), .op2(op2),
    .imm(imm), .npci(npci), .regdesti(regdesti), .ldsti(ldsti),
    .instructioni(instructioni)
  );

  // Architectural model
  logic [15:0] m_rf [16];
  bit          m_busy [16];
  logic        m_ov;
  logic [15:0] m_op1, m_op2;
  logic [7:0]  m_imm, m_npci;
  logic [3:0]  m_rd, m_ldst, m_ins;
  logic        obs_ready, m_ready;

  function automatic logic model_ready(input logic [15:0] ins, input logic we, input logic [3:0] wr);
    int srcs[$];
    case (ins[15:12])
      4'd0, 4'd1, 4'd2: begin srcs.push_back(int'(ins[7:4])); srcs.push_back(int'(ins[3:0])); end
      4'd4: srcs.push_back(int'(ins[11:8]));
      4'd5, 4'd6: begin srcs.push_back(int'(ins[11:8])); srcs.push_back(int'(ins[7:4])); end
      default: ;
    endcase
    foreach (srcs[k])
      if (m_busy[srcs[k]] && !(we && int'(wr) == srcs[k])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] model_read(input logic [3:0] idx, input logic we,
                                             input logic [3:0] wr, input logic [15:0] wd);
    return (we && wr == idx) ? wd : m_rf[idx];
  endfunction

  function automatic logic [60:0] dut_out();
    return {out_valid, op1, op2, imm, npci, regdesti, ldsti, instructioni};
  endfunction

  function automatic logic [60:0] model_out();
    return {m_ov, m_op1, m_op2, m_imm, m_npci, m_rd, m_ldst, m_ins};
  endfunction

  // Drives one cycle, captures in_ready before the edge, advances the model.
  task automatic drive_cycle(input logic v, input logic [15:0] ins, input logic [7:0] pc,
                             input logic we, input logic [3:0] wr, input logic [15:0] wd,
                             input logic fl, input logic rn);
    logic acc;
    logic [3:0] op, a, b, c;
    in_valid = v; in_instr = ins; in_pc = pc; wb_en = we; wb_reg = wr;
    wb_data = wd; flush = fl; resetn = rn;
    #1;
    obs_ready = in_ready;
    m_ready   = model_ready(ins, we, wr);
    op = ins[15:12]; a = ins[11:8]; b = ins[7:4]; c = ins[3:0];
    acc = v && m_ready && !fl;
    if (!rn) begin
      foreach (m_rf[i]) begin m_rf[i] = INIT; m_busy[i] = 1'b0; end
      m_ov = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_npci = 0; m_rd = 0; m_ldst = 0; m_ins = 0;
    end else begin
      m_ov = 1'b0;
      if (acc && op <= 4'd6) begin
        m_ov = 1'b1; m_ins = op; m_npci = pc + 8'd1;
        m_op1 = 0; m_op2 = 0; m_imm = 0; m_ldst = 0; m_rd = 0;
        if (op <= 4'd2) begin
          m_op1 = model_read(b, we, wr, wd); m_op2 = model_read(c, we, wr, wd); m_rd = a;
        end else if (op == 4'd3) begin
          m_imm = {b, c}; m_ldst = c; m_rd = a;
        end else if (op == 4'd4) begin
          m_op2 = model_read(a, we, wr, wd); m_imm = {b, c}; m_ldst = c;
        end else begin
          m_op1 = model_read(a, we, wr, wd); m_op2 = model_read(b, we, wr, wd); m_imm = {4'b0, c};
        end
      end
      if (we) begin m_rf[wr] = wd; m_busy[wr] = 1'b0; end
      if (acc && op <= 4'd3) m_busy[a] = 1'b1;
    end
    @(posedge clkwire);
    #1;
  endtask

  task automatic idle_wb(input logic [3:0] r, input logic [15:0] d);
    drive_cycle(1'b0, 16'h0000, 8'h00, 1'b1, r, d, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    drive_cycle(1'b0, 16'h0000, 8'h00, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    drive_cycle(1'b0, 16'h0000, 8'h00, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    n_checks++;
    if (dut_out() !== 61'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", dut_out());
    end
    drive_cycle(1'b0, 16'h0512, 8'h00, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", obs_ready);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_cycle(1'b1, 16'h3300, 8'h10, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    drive_cycle(1'b1, 16'h0533, 8'h11, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if (obs_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_before_reset: got %b expected 0", obs_ready);
    end
    drive_cycle(1'b1, 16'h0533, 8'h11, 1'b1, 4'd3, 16'hBEEF, 1'b1, 1'b0);
    n_checks++;
    if (dut_out() !== 61'd0) begin
      n_fail++; $display("FAIL midstall_reset_outputs: got %h expected 0", dut_out());
    end
    drive_cycle(1'b1, 16'h0533, 8'h20, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL midstall_ready: got %b expected 1", obs_ready);
    end
    n_checks++;
    if ({out_valid, op1, op2} !== {1'b1, INIT, INIT}) begin
      n_fail++; $display("FAIL midstall_rf_init: got %b %h %h expected 1 %h %h", out_valid, op1, op2, INIT, INIT);
    end
    idle_wb(4'd5, 16'h0000);
  endtask

  task automatic test_add();
    idle_wb(4'd1, 16'd10);
    idle_wb(4'd2, 16'd12);
    drive_cycle(1'b1, 16'h0512, 8'd9, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if ({out_valid, op1, op2} !== {1'b1, 16'd10, 16'd12}) begin
      n_fail++; $display("FAIL add_operands: got %b %0d %0d expected 1 10 12", out_valid, op1, op2);
    end
    n_checks++;
    if ({npci, regdesti, instructioni, imm, ldsti} !== {8'd10, 4'd5, 4'd0, 8'd0, 4'd0}) begin
      n_fail++; $display("FAIL add_fields: got npci=%0d rd=%0d ins=%0d imm=%0d ld=%0d expected 10 5 0 0 0",
                         npci, regdesti, instructioni, imm, ldsti);
    end
    idle_wb(4'd5, 16'd22);
  endtask

  task automatic test_hazard();
    drive_cycle(1'b1, 16'h1312, 8'd20, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b1, 16'h0431, 8'd21, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
      n_checks++;
      if (obs_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL hazard_stall: got ready=%b ov=%b expected 0 0", obs_ready, out_valid);
      end
    end
    drive_cycle(1'b1, 16'h0431, 8'd21, 1'b1, 4'd3, 16'h0077, 1'b0, 1'b1);
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL hazard_release: got %b expected 1", obs_ready);
    end
    n_checks++;
    if ({out_valid, op1, op2, regdesti} !== {1'b1, 16'h0077, 16'd10, 4'd4}) begin
      n_fail++; $display("FAIL hazard_bypass: got %b %h %h %0d expected 1 0077 000a 4", out_valid, op1, op2, regdesti);
    end
    idle_wb(4'd4, 16'h0001);
  endtask

  task automatic test_load();
    drive_cycle(1'b1, 16'h3739, 8'd30, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if ({out_valid, ldsti, imm, regdesti, op1, op2} !== {1'b1, 4'd9, 8'h39, 4'd7, 16'd0, 16'd0}) begin
      n_fail++; $display("FAIL load_fields: got ov=%b ld=%0d imm=%h rd=%0d op1=%h op2=%h expected 1 9 39 7 0 0",
                         out_valid, ldsti, imm, regdesti, op1, op2);
    end
    drive_cycle(1'b0, 16'h4700, 8'd31, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if (obs_ready !== 1'b0) begin
      n_fail++; $display("FAIL load_busy_set: got ready=%b expected 0", obs_ready);
    end
    idle_wb(4'd7, 16'h00AB);
    drive_cycle(1'b1, 16'h4712, 8'd32, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL load_busy_clear: got ready=%b expected 1", obs_ready);
    end
    n_checks++;
    if ({out_valid, op1, op2, imm, ldsti, regdesti} !== {1'b1, 16'd0, 16'h00AB, 8'h12, 4'd2, 4'd0}) begin
      n_fail++; $display("FAIL store_fields: got %b %h %h %h %0d %0d expected 1 0000 00ab 12 2 0",
                         out_valid, op1, op2, imm, ldsti, regdesti);
    end
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 16'h3800, 8'd40, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    drive_cycle(1'b1, 16'h0911, 8'd41, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid);
    end
    drive_cycle(1'b0, 16'h4800, 8'd42, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if (obs_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_busy_kept: got ready=%b expected 0", obs_ready);
    end
    drive_cycle(1'b1, 16'h4900, 8'd43, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if (obs_ready !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_no_busy_set: got ready=%b ov=%b expected 1 1", obs_ready, out_valid);
    end
    idle_wb(4'd8, 16'h0008);
  endtask

  task automatic test_boundary();
    logic [15:0] ins;
    drive_cycle(1'b1, 16'h0612, 8'd255, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if ({out_valid, npci} !== {1'b1, 8'd0}) begin
      n_fail++; $display("FAIL npci_wrap: got ov=%b npci=%0d expected 1 0", out_valid, npci);
    end
    idle_wb(4'd6, 16'h0006);
    for (int op = 7; op < 16; op++) begin
      ins = {4'(op), 12'h123};
      drive_cycle(1'b1, ins, 8'd50, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
      n_checks++;
      if (obs_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL nop_op%0d: got ready=%b ov=%b expected 1 0", op, obs_ready, out_valid);
      end
    end
    drive_cycle(1'b1, 16'h4100, 8'd51, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL nop_no_busy: got ready=%b expected 1", obs_ready);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic [3:0]  op;
    for (int n = 0; n < 3000; n++) begin
      op  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(7, 15));
      ins = {op, 12'($urandom)};
      drive_cycle(1'($urandom_range(0, 3) != 0), ins, 8'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 199) != 0));
      n_checks++;
      if (obs_ready !== m_ready) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, obs_ready, m_ready);
      end
      n_checks++;
      if (dut_out() !== model_out()) begin
        n_fail++; $display("FAIL rand_outputs[%0d]: got %h expected %h", n, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_stall();
    test_add();
    test_hazard();
    test_load();
    test_flush();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
